// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, widths and helpers for the conv channel sequencer
package conv_pkg;

    localparam int COUT_W       = 4;
    localparam int PIPE_LAT_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Valid convolution, stride 1.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win_raster_cnt.sv
// rtl/win_raster_cnt.sv - raster row/col window counter with compare-equal wraps
module win_raster_cnt
    import conv_pkg::*;
#(
    parameter int OUT_W = 26,
    parameter int OUT_H = 26,
    parameter int RW    = cnt_w(OUT_H),
    parameter int CW    = cnt_w(OUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == CW'(OUT_W - 1));
    assign row_end = (row == RW'(OUT_H - 1));
    assign last    = col_end & row_end;

    // Advancing past the last window returns to (0,0) so row never leaves range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_channel_sequencer.sv
// rtl/conv_channel_sequencer.sv - per-layer output-channel sequencer; optional SEQ_STALL_CNT_EN stall counter
module conv_channel_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_COUT = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 3,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int OUT_W    = out_dim(IMG_W, K),
    parameter int OUT_H    = out_dim(IMG_H, K),
    parameter int RW       = cnt_w(OUT_H),
    parameter int CW       = cnt_w(OUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [3:0]    cout,
    output logic          c_load,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_win
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int DW = cnt_w(PIPE_LAT);

    seq_state_t    state;
    logic [DW-1:0] drain_cnt;
    logic          last;
    logic          launch;
    logic          chan_end;

    assign launch   = (state == S_IDLE) && start;
    // Channel finishes on the last DRAIN cycle, or on the last accept when there is no pipeline.
    assign chan_end = ((state == S_RUN) && win_ready && last && (PIPE_LAT == 0)) ||
                      ((state == S_DRAIN) && (drain_cnt == '0));
    assign last_win = win_valid & last;

    win_raster_cnt #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .RW    (RW),
        .CW    (CW)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch | chan_end),
        .adv  ((state == S_RUN) && win_ready),
        .row  (row),
        .col  (col),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            c_load    <= 1'b0;
            win_valid <= 1'b0;
            cout      <= '0;
            drain_cnt <= '0;
        end else begin
            done   <= 1'b0;
            c_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        busy   <= 1'b1;
                        c_load <= 1'b1;
                        cout   <= '0;
                    end
                end
                S_LOAD: begin
                    state     <= S_RUN;
                    win_valid <= 1'b1;
                end
                S_RUN: begin
                    if (win_ready && last) begin
                        state     <= S_DRAIN;
                        win_valid <= 1'b0;
                        drain_cnt <= DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (chan_end) begin
                if (cout == COUT_W'(NUM_COUT - 1)) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state  <= S_LOAD;
                    cout   <= cout + COUT_W'(1);
                    c_load <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (launch) begin
            stall_cnt <= '0;
        end else if ((state == S_RUN) && !win_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_channel_sequencer.sv
// tb/tb_conv_channel_sequencer.sv - self-checking bench for conv_channel_sequencer
module tb_conv_channel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       win_ready = 1'b1;
    logic [1:0] sel = 2'd0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic       busy_a, done_a, c_load_a, wv_a, last_a;
    logic [3:0] cout_a;
    logic [1:0] row_a, col_a;
    logic       busy_b, done_b, c_load_b, wv_b, last_b;
    logic [3:0] cout_b;
    logic [1:0] row_b, col_b;
    logic       busy_c, done_c, c_load_c, wv_c, last_c;
    logic [3:0] cout_c;
    logic [4:0] row_c, col_c;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_a, stall_b, stall_c;
`endif

    conv_channel_sequencer #(.NUM_COUT(2), .IMG_W(5), .IMG_H(5), .K(3), .PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start & (sel == 2'd0)), .busy(busy_a), .done(done_a),
        .cout(cout_a), .c_load(c_load_a), .win_valid(wv_a), .win_ready(win_ready | (sel != 2'd0)),
        .row(row_a), .col(col_a), .last_win(last_a)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    conv_channel_sequencer #(.NUM_COUT(1), .IMG_W(5), .IMG_H(5), .K(3), .PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start & (sel == 2'd1)), .busy(busy_b), .done(done_b),
        .cout(cout_b), .c_load(c_load_b), .win_valid(wv_b), .win_ready(win_ready | (sel != 2'd1)),
        .row(row_b), .col(col_b), .last_win(last_b)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    conv_channel_sequencer #(.NUM_COUT(8), .IMG_W(28), .IMG_H(28), .K(3), .PIPE_LAT(4)) dut_c (
        .clk(clk), .rst(rst), .start(start & (sel == 2'd2)), .busy(busy_c), .done(done_c),
        .cout(cout_c), .c_load(c_load_c), .win_valid(wv_c), .win_ready(win_ready | (sel != 2'd2)),
        .row(row_c), .col(col_c), .last_win(last_c)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cnt(stall_c)
`endif
    );

    logic       o_busy, o_done, o_c_load, o_wv, o_last;
    logic [3:0] o_cout;
    logic [7:0] o_row, o_col;

    always_comb begin
        o_busy = busy_a; o_done = done_a; o_c_load = c_load_a; o_wv = wv_a; o_last = last_a;
        o_cout = cout_a; o_row = 8'(row_a); o_col = 8'(col_a);
        case (sel)
            2'd1: begin
                o_busy = busy_b; o_done = done_b; o_c_load = c_load_b; o_wv = wv_b; o_last = last_b;
                o_cout = cout_b; o_row = 8'(row_b); o_col = 8'(col_b);
            end
            2'd2: begin
                o_busy = busy_c; o_done = done_c; o_c_load = c_load_c; o_wv = wv_c; o_last = last_c;
                o_cout = cout_c; o_row = 8'(row_c); o_col = 8'(col_c);
            end
            default: ;
        endcase
    end

    logic       tr_busy[64], tr_done[64], tr_c_load[64], tr_wv[64], tr_last[64];
    logic [3:0] tr_cout[64];
    logic [7:0] tr_row[64], tr_col[64];

    typedef struct {
        int         cyc;
        logic       busy, done, c_load, wv;
        logic [3:0] cout;
        logic [7:0] row, col;
        logic       last;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch one layer and observe max_cyc cycles; cycle 1 is the cycle right after the start edge.
    task automatic run_layer(input int max_cyc, input int stall_at, input int stall_len, input int pulse_at,
                             output int done_cyc, output int n_win, output int n_load,
                             output int n_done, output int n_bad);
        done_cyc = -1; n_win = 0; n_load = 0; n_done = 0; n_bad = 0;
        @(negedge clk);
        start = 1'b1;
        win_ready = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            win_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (c < 64) begin
                tr_busy[c] = o_busy; tr_done[c] = o_done; tr_c_load[c] = o_c_load; tr_wv[c] = o_wv;
                tr_last[c] = o_last; tr_cout[c] = o_cout; tr_row[c] = o_row; tr_col[c] = o_col;
            end
            if (o_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (o_c_load) n_load++;
            if (o_c_load && o_wv) n_bad++;
            if (o_wv && win_ready) n_win++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, nw, nl, nd, nb;
        int exp_cout, exp_r, exp_c, gap, order_err, wv_bad, loads, wins, seen_done;

        vecs[0]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0};
        vecs[1]  = '{2,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 1'b0};
        vecs[2]  = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0, 8'd1, 1'b0};
        vecs[3]  = '{5,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 8'd0, 1'b0};
        vecs[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0};
        vecs[5]  = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 8'd2, 8'd2, 1'b1};
        vecs[6]  = '{11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0};
        vecs[7]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0};
        vecs[8]  = '{13, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd0, 8'd0, 1'b0};
        vecs[9]  = '{14, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 8'd0, 1'b0};
        vecs[10] = '{22, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd2, 8'd2, 1'b1};
        vecs[11] = '{24, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0, 8'd0, 1'b0};
        vecs[12] = '{25, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0, 8'd0, 1'b0};
        vecs[13] = '{26, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0, 8'd0, 1'b0};

        // Power-on reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cout", 32'(o_cout), 0);
        chk("rst_wv", 32'(o_wv), 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: asynchronous reset mid-RUN, channel 1, row 1
        run_layer(17, 0, 0, 0, dc, nw, nl, nd, nb);
        chk("t1_pre_cout", 32'(o_cout), 1);
        chk("t1_pre_row", 32'(o_row), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_busy", 32'(o_busy), 0);
        chk("t1_done", 32'(o_done), 0);
        chk("t1_c_load", 32'(o_c_load), 0);
        chk("t1_wv", 32'(o_wv), 0);
        chk("t1_last", 32'(o_last), 0);
        chk("t1_cout", 32'(o_cout), 0);
        chk("t1_row", 32'(o_row), 0);
        chk("t1_col", 32'(o_col), 0);
        @(negedge clk);
        rst = 1'b1;
        run_layer(27, 0, 0, 0, dc, nw, nl, nd, nb);
        chk("t1_relaunch_done_cyc", 32'(dc), 25);

        // 2: full layer, win_ready stuck high
        run_layer(27, 0, 0, 0, dc, nw, nl, nd, nb);
        for (int i = 0; i < 14; i++) begin
            int c;
            c = vecs[i].cyc;
            chk($sformatf("t2_c%0d_busy", c), 32'(tr_busy[c]), 32'(vecs[i].busy));
            chk($sformatf("t2_c%0d_done", c), 32'(tr_done[c]), 32'(vecs[i].done));
            chk($sformatf("t2_c%0d_c_load", c), 32'(tr_c_load[c]), 32'(vecs[i].c_load));
            chk($sformatf("t2_c%0d_wv", c), 32'(tr_wv[c]), 32'(vecs[i].wv));
            chk($sformatf("t2_c%0d_cout", c), 32'(tr_cout[c]), 32'(vecs[i].cout));
            chk($sformatf("t2_c%0d_row", c), 32'(tr_row[c]), 32'(vecs[i].row));
            chk($sformatf("t2_c%0d_col", c), 32'(tr_col[c]), 32'(vecs[i].col));
            chk($sformatf("t2_c%0d_last", c), 32'(tr_last[c]), 32'(vecs[i].last));
        end
        chk("t2_done_cyc", 32'(dc), 25);
        chk("t2_windows", 32'(nw), 18);
        chk("t2_loads", 32'(nl), 2);
        chk("t2_load_wv_overlap", 32'(nb), 0);
`ifdef SEQ_STALL_CNT_EN
        chk("t2_stall_cnt", 32'(stall_a), 0);
`endif

        // 3: three stalled cycles at window (1,1)
        run_layer(30, 6, 3, 0, dc, nw, nl, nd, nb);
        for (int c = 6; c <= 9; c++) begin
            chk($sformatf("t3_c%0d_row", c), 32'(tr_row[c]), 1);
            chk($sformatf("t3_c%0d_col", c), 32'(tr_col[c]), 1);
            chk($sformatf("t3_c%0d_wv", c), 32'(tr_wv[c]), 1);
        end
        chk("t3_c10_col", 32'(tr_col[10]), 2);
        chk("t3_done_cyc", 32'(dc), 28);
        chk("t3_windows", 32'(nw), 18);
`ifdef SEQ_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(stall_a), 3);
`endif

        // 4: start pulsed while busy is ignored; a later start relaunches at cout 0
        run_layer(40, 0, 0, 5, dc, nw, nl, nd, nb);
        chk("t4_done_count", 32'(nd), 1);
        chk("t4_done_cyc", 32'(dc), 25);
        chk("t4_loads", 32'(nl), 2);
        chk("t4_idle_busy", 32'(tr_busy[35]), 0);
        chk("t4_end_cout", 32'(o_cout), 1);
        run_layer(27, 0, 0, 0, dc, nw, nl, nd, nb);
        chk("t4_relaunch_c_load", 32'(tr_c_load[1]), 1);
        chk("t4_relaunch_cout", 32'(tr_cout[1]), 0);
        chk("t4_relaunch_done_cyc", 32'(dc), 25);

        // 5: no pipeline, single channel
        sel = 2'd1;
        run_layer(13, 0, 0, 0, dc, nw, nl, nd, nb);
        chk("t5_done_cyc", 32'(dc), 11);
        chk("t5_windows", 32'(nw), 9);
        chk("t5_loads", 32'(nl), 1);
        chk("t5_c10_last", 32'(tr_last[10]), 1);
        chk("t5_c11_wv", 32'(tr_wv[11]), 0);
        chk("t5_c12_busy", 32'(tr_busy[12]), 0);

        // 6: 8 channels of 26x26 windows under random backpressure
        sel = 2'd2;
        exp_cout = 0; exp_r = 0; exp_c = 0; gap = 1;
        order_err = 0; wv_bad = 0; loads = 0; wins = 0; seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30000 && seen_done == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            win_ready = 1'($urandom_range(0, 1));
            if (o_c_load) begin
                loads++;
                if (!gap || o_cout != 4'(exp_cout)) order_err++;
                gap = 0;
            end
            if (o_wv && (gap || o_c_load)) wv_bad++;
            if (o_wv && win_ready && !gap) begin
                wins++;
                if (o_cout != 4'(exp_cout) || o_row != 8'(exp_r) || o_col != 8'(exp_c) ||
                    o_last != (exp_r == 25 && exp_c == 25))
                    order_err++;
                if (exp_c == 25) begin
                    exp_c = 0;
                    if (exp_r == 25) begin
                        exp_r = 0;
                        exp_cout++;
                        gap = 1;
                    end else begin
                        exp_r++;
                    end
                end else begin
                    exp_c++;
                end
            end
            if (o_done) seen_done = 1;
        end
        win_ready = 1'b1;
        chk("t6_done_seen", 32'(seen_done), 1);
        chk("t6_windows", 32'(wins), 8 * 676);
        chk("t6_loads", 32'(loads), 8);
        chk("t6_order_errs", 32'(order_err), 0);
        chk("t6_wv_outside_run", 32'(wv_bad), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
